// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned MAX_WIDTH     = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  // Quotient pattern reported on a divide by zero: all ones across the operand width.
  function automatic logic [MAX_WIDTH-1:0] div_zero_lo(input int unsigned width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < MAX_WIDTH; k++) begin
      if (k < width) v[k] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the main FSM (master) and the divider (slave).
interface div_if import div_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividendo;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, is_signed, dividendo, divisor,
    input  busy, done, div_zero, HI, LO
  );

  modport slave (
    input  start, is_signed, dividendo, divisor,
    output busy, done, div_zero, HI, LO
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, subtract divisor when it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  localparam int unsigned RW = WIDTH + 1;

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] dvs_ext;
  logic             ge;

  always_comb begin
    sh      = {rem_in, quo_in[WIDTH-1]};
    dvs_ext = {2'b00, divisor};
    ge      = (sh >= dvs_ext);
    rem_out = RW'(ge ? (sh - dvs_ext) : sh);
    quo_out = {quo_in[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider: quotient to LO, remainder to HI.
module div_unit import div_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic  clk,
  input logic  reset_n,
  div_if.slave bus
);

  localparam int unsigned     CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned     RW    = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e       state;
  logic [RW-1:0]    rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic             neg_a;
  logic             neg_b;

  logic [RW-1:0]    rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             neg_a_in;
  logic             neg_b_in;
  logic [WIDTH-1:0] abs_a_in;
  logic [WIDTH-1:0] abs_b_in;
  logic [WIDTH-1:0] rem_w;
  logic             dvs_zero;

  // Operand magnitudes; signs only matter in signed mode.
  always_comb begin
    neg_a_in = bus.is_signed & bus.dividendo[WIDTH-1];
    neg_b_in = bus.is_signed & bus.divisor[WIDTH-1];
    abs_a_in = neg_a_in ? -bus.dividendo : bus.dividendo;
    abs_b_in = neg_b_in ? -bus.divisor : bus.divisor;
    dvs_zero = (bus.divisor == '0);
    rem_w    = WIDTH'(rem);
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvs),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      cnt          <= '0;
      neg_a        <= 1'b0;
      neg_b        <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.HI       <= '0;
      bus.LO       <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_a        <= neg_a_in;
            neg_b        <= neg_b_in;
            quo          <= abs_a_in;
            dvs          <= abs_b_in;
            rem          <= '0;
            cnt          <= '0;
            bus.div_zero <= dvs_zero;
            if (dvs_zero) begin
              // Divide by zero skips the iterations and reports the raw dividend.
              bus.HI   <= bus.dividendo;
              bus.LO   <= WIDTH'(div_zero_lo(WIDTH));
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              bus.busy <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          // Truncating division: remainder follows the dividend's sign.
          bus.LO   <= (neg_a ^ neg_b) ? -quo : quo;
          bus.HI   <= neg_a ? -rem_w : rem_w;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed 32-bit cases plus randomized 8-bit traffic.
module tb_div_unit;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_if #(.WIDTH(32)) b32 ();
  div_if #(.WIDTH(8))  b8 ();

  div_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(rst_n), .bus(b32.slave));
  div_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(rst_n), .bus(b8.slave));

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  int          issued  [2];
  int          retired [2];
  logic [31:0] e_hi    [2];
  logic [31:0] e_lo    [2];
  logic        e_dz    [2];
  int          e_cyc   [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer division on sign-extended operands.
  function automatic void model(input int unsigned w, input bit sgn,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz);
    longint mask, ua, ub, sa, sb, q, r;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    if (ub == 0) begin
      hi = 32'(ua);
      lo = 32'(mask);
      dz = 1'b1;
      return;
    end
    dz = 1'b0;
    if (sgn) begin
      sa = ua[w-1] ? ua - (longint'(1) << w) : ua;
      sb = ub[w-1] ? ub - (longint'(1) << w) : ub;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    lo = 32'(q & mask);
    hi = 32'(r & mask);
  endfunction

  function automatic void get_out(input int i, output logic [31:0] hi, output logic [31:0] lo,
                                  output logic bz, output logic dn, output logic dz);
    if (i == 0) begin
      hi = b32.HI; lo = b32.LO; bz = b32.busy; dn = b32.done; dz = b32.div_zero;
    end else begin
      hi = {24'd0, b8.HI}; lo = {24'd0, b8.LO}; bz = b8.busy; dn = b8.done; dz = b8.div_zero;
    end
  endfunction

  task automatic drive(input int i, input logic st, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin
      b32.start = st; b32.is_signed = sgn; b32.dividendo = a; b32.divisor = b;
    end else begin
      b8.start = st; b8.is_signed = sgn; b8.dividendo = a[7:0]; b8.divisor = b[7:0];
    end
  endtask

  // Compare process: every outstanding operation is checked cycle by cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] hi, lo;
        logic bz, dn, dz;
        get_out(i, hi, lo, bz, dn, dz);
        if (dn) begin
          chk("done_expected", 32'(issued[i] != retired[i]), 32'd1);
          if (issued[i] != retired[i]) begin
            chk("latency", 32'(cyc), 32'(e_cyc[i]));
            chk("LO", lo, e_lo[i]);
            chk("HI", hi, e_hi[i]);
            chk("div_zero", 32'(dz), 32'(e_dz[i]));
            chk("busy_with_done", 32'(bz), 32'd0);
            retired[i] <= retired[i] + 1;
          end
        end else if (issued[i] != retired[i]) begin
          if (cyc >= e_cyc[i]) begin
            chk("done_on_time", 32'(dn), 32'd1);
            retired[i] <= retired[i] + 1;
          end else if (!e_dz[i]) begin
            chk("busy_in_flight", 32'(bz), 32'd1);
          end
        end
      end
    end
  end

  task automatic start_op(input int i, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int unsigned w;
    w = (i == 0) ? 32 : 8;
    @(negedge clk);
    drive(i, 1'b1, sgn, a, b);
    @(posedge clk);
    #1;
    model(w, sgn, a, b, e_hi[i], e_lo[i], e_dz[i]);
    e_cyc[i] = cyc + (e_dz[i] ? 0 : int'(w) + 1);
    issued[i]++;
    drive(i, 1'b0, 1'($urandom), $urandom, $urandom);
  endtask

  task automatic wait_op(input int i);
    int k;
    k = 0;
    while (issued[i] != retired[i] && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (issued[i] != retired[i]) begin
      chk("op_timeout", 32'(retired[i]), 32'(issued[i]));
      issued[i] = retired[i];
    end
  endtask

  task automatic run_op(input int i, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    start_op(i, sgn, a, b);
    wait_op(i);
  endtask

  task automatic pin(input string name, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lo_x, input logic [31:0] hi_x, input logic dz_x);
    logic [31:0] hi, lo;
    logic dz;
    model(32, sgn, a, b, hi, lo, dz);
    chk({name, "_lo"}, lo, lo_x);
    chk({name, "_hi"}, hi, hi_x);
    chk({name, "_dz"}, 32'(dz), 32'(dz_x));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    bit sgn;
    issued[0] = 0; issued[1] = 0;
    retired[0] = 0; retired[1] = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(b32.busy), 32'd0);
    chk("rst_done", 32'(b32.done), 32'd0);
    chk("rst_dz", 32'(b32.div_zero), 32'd0);
    chk("rst_HI", b32.HI, 32'd0);
    chk("rst_LO", b32.LO, 32'd0);
    chk("rst8_busy", 32'(b8.busy), 32'd0);
    rst_n = 1'b1;

    // Hand-computed anchors for the reference model.
    pin("m_u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    pin("m_sn100_7", 1'b1, -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    pin("m_s100_n7", 1'b1, 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0);
    pin("m_dz", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    pin("m_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    pin("m_umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);

    // Directed 32-bit operations.
    run_op(0, 1'b0, 32'd100, 32'd7);
    run_op(0, 1'b1, -32'sd100, 32'd7);
    run_op(0, 1'b1, 32'd100, -32'sd7);
    run_op(0, 1'b0, 32'h1234, 32'd0);
    start_op(0, 1'b0, 32'd9, 32'd4);
    chk("dz_cleared_on_start", 32'(b32.div_zero), 32'd0);
    wait_op(0);
    run_op(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(0, 1'b1, 32'h8000_0000, 32'd0);

    // A start pulsed mid-CALC must not disturb the running operation.
    start_op(0, 1'b0, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'd5, 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_op(0);

    // Asynchronous reset in the middle of the iterations.
    start_op(0, 1'b1, -32'sd77777, 32'd13);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(b32.busy), 32'd0);
    chk("mid_rst_done", 32'(b32.done), 32'd0);
    chk("mid_rst_HI", b32.HI, 32'd0);
    chk("mid_rst_LO", b32.LO, 32'd0);
    issued[0] = retired[0];
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b1, -32'sd77777, 32'd13);

    // Some random 32-bit traffic.
    for (int n = 0; n < 40; n++) begin
      sgn = 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      run_op(0, sgn, a, b);
    end

    // Randomized 8-bit traffic, signed and unsigned, with edge operands mixed in.
    for (int n = 0; n < 1000; n++) begin
      sgn = 1'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h80; b = 32'hFF; end
        2: b = 32'hFF;
        3: a = 32'h80;
        default: ;
      endcase
      run_op(1, sgn, a, b);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
